// File: rtl/iir_pkg.sv
// Shared definitions for the biquad MAC scheduler.
// State encoding, operand selects and the coefficient index helper.
package iir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WB,
        S_DONE
    } state_t;

    localparam int TAPS_PER_SEC = 5;

    localparam logic [2:0] OP_X0 = 3'd0;
    localparam logic [2:0] OP_X1 = 3'd1;
    localparam logic [2:0] OP_X2 = 3'd2;
    localparam logic [2:0] OP_Y1 = 3'd3;
    localparam logic [2:0] OP_Y2 = 3'd4;

    // 5*sec + tap, with the multiply built as (sec<<2)+sec
    function automatic logic [7:0] coef_idx(
        input logic [3:0] sec,
        input logic [2:0] tap
    );
        return {2'b00, sec, 2'b00} + {4'b0000, sec} + {5'b00000, tap};
    endfunction

endpackage

// File: rtl/iir_tap_counter.sv
// Shared tap / drain counter for the scheduler state machine.
// Flags the last tap of a section and the last drain cycle.
module iir_tap_counter
    import iir_pkg::*;
#(
    parameter int MAC_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] cnt,
    output logic       tap_last,
    output logic       drn_last
);

    localparam logic [2:0] TLAST = 3'(TAPS_PER_SEC - 1);
    localparam logic [2:0] DLAST = (MAC_LAT > 0) ? 3'(MAC_LAT - 1) : 3'd0;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= 3'd0;
        end else if (inc) begin
            cnt <= cnt + 3'd1;
        end
    end

    assign tap_last = (cnt == TLAST);
    assign drn_last = (cnt == DLAST);

endmodule

// File: rtl/iir_mac_scheduler.sv
// Control sequencer for a shared-MAC Direct Form I biquad cascade.
// Each accepted sample runs 5 MACs, a drain and a writeback per section.
module iir_mac_scheduler
    import iir_pkg::*;
#(
    parameter int SECTIONS = 4,
    parameter int MAC_LAT  = 2,
    parameter int CADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic               clear_ovr,
    output logic               busy,
    output logic               mac_en,
    output logic               mac_clr,
    output logic [2:0]         op_sel,
    output logic [CADDR_W-1:0] coef_addr,
    output logic [3:0]         sec_idx,
    output logic               wb_en,
    output logic               out_valid,
    output logic               overrun
);

    localparam logic [3:0] SEC_LAST = 4'(SECTIONS - 1);

    state_t     state;
    logic [3:0] sec;
    logic [2:0] cnt;
    logic       tap_last;
    logic       drn_last;
    logic       cnt_inc;
    logic       cnt_clr;
    logic       in_sched;

    // Counter is held at zero whenever it is not stepping
    always_comb begin
        cnt_inc = 1'b0;
        if (state == S_MAC && !tap_last) cnt_inc = 1'b1;
        if (state == S_DRAIN && !drn_last) cnt_inc = 1'b1;
        cnt_clr = !cnt_inc;
    end

    assign in_sched = (state == S_MAC) || (state == S_DRAIN)
                   || (state == S_WB);

    iir_tap_counter #(
        .MAC_LAT (MAC_LAT)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .tap_last (tap_last),
        .drn_last (drn_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            sec       <= 4'd0;
            busy      <= 1'b0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            op_sel    <= 3'd0;
            coef_addr <= '0;
            wb_en     <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            wb_en     <= 1'b0;
            out_valid <= 1'b0;

            if (sample_valid && in_sched) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (sample_valid) begin
                        state     <= S_MAC;
                        sec       <= 4'd0;
                        busy      <= 1'b1;
                        mac_en    <= 1'b1;
                        mac_clr   <= 1'b1;
                        op_sel    <= OP_X0;
                        coef_addr <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_MAC: begin
                    if (!tap_last) begin
                        mac_en    <= 1'b1;
                        op_sel    <= cnt + 3'd1;
                        coef_addr <= CADDR_W'(coef_idx(sec, cnt + 3'd1));
                    end else if (MAC_LAT > 0) begin
                        state <= S_DRAIN;
                    end else begin
                        state <= S_WB;
                        wb_en <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drn_last) begin
                        state <= S_WB;
                        wb_en <= 1'b1;
                    end
                end
                S_WB: begin
                    if (sec == SEC_LAST) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state     <= S_MAC;
                        sec       <= sec + 4'd1;
                        mac_en    <= 1'b1;
                        mac_clr   <= 1'b1;
                        op_sel    <= OP_X0;
                        coef_addr <= CADDR_W'(coef_idx(sec + 4'd1, 3'd0));
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sec_idx = sec;

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Directed bench for iir_mac_scheduler (default and LAT=0/1-section builds).
module tb_iir_mac_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sv, clr, sv1, clr1;

    logic       busy, mac_en, mac_clr, wb_en, out_valid, overrun;
    logic [2:0] op_sel;
    logic [5:0] coef_addr;
    logic [3:0] sec_idx;

    logic       busy1, mac_en1, mac_clr1, wb_en1, out_valid1, overrun1;
    logic [2:0] op_sel1;
    logic [2:0] coef_addr1;
    logic [3:0] sec_idx1;

    int n_cmp = 0;
    int n_err = 0;
    int last_addr = 0;

    iir_mac_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sv),
        .clear_ovr    (clr),
        .busy         (busy),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .op_sel       (op_sel),
        .coef_addr    (coef_addr),
        .sec_idx      (sec_idx),
        .wb_en        (wb_en),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    iir_mac_scheduler #(
        .SECTIONS (1),
        .MAC_LAT  (0),
        .CADDR_W  (3)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sv1),
        .clear_ovr    (clr1),
        .busy         (busy1),
        .mac_en       (mac_en1),
        .mac_clr      (mac_clr1),
        .op_sel       (op_sel1),
        .coef_addr    (coef_addr1),
        .sec_idx      (sec_idx1),
        .wb_en        (wb_en1),
        .out_valid    (out_valid1),
        .overrun      (overrun1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected default-build outputs c cycles after the accepted strobe
    task automatic chk_nom(input int c, input string ph);
        int  k, p;
        bit  in_mac, wb;
        k = (c - 1) / 8;
        p = (c - 1) % 8;
        in_mac = (c >= 1) && (c <= 32) && (p < 5);
        wb = (c >= 8) && (c <= 32) && (c % 8 == 0);
        if (in_mac) last_addr = 5 * k + p;
        chk($sformatf("%s c%0d mac_en", ph, c), mac_en, in_mac);
        chk($sformatf("%s c%0d mac_clr", ph, c), mac_clr, in_mac && p == 0);
        chk($sformatf("%s c%0d wb_en", ph, c), wb_en, wb);
        chk($sformatf("%s c%0d out_valid", ph, c), out_valid, c == 33);
        chk($sformatf("%s c%0d busy", ph, c), busy, c >= 1 && c <= 33);
        chk($sformatf("%s c%0d coef_addr", ph, c), coef_addr, last_addr);
        if (in_mac) begin
            chk($sformatf("%s c%0d op_sel", ph, c), op_sel, p);
            chk($sformatf("%s c%0d sec_idx", ph, c), sec_idx, k);
        end
        if (wb) chk($sformatf("%s c%0d wb sec", ph, c), sec_idx, c / 8 - 1);
    endtask

    initial begin
        int n_ov, max_addr;
        bit ovr_seen;

        rst = 1'b0; sv = 1'b0; clr = 1'b0; sv1 = 1'b0; clr1 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;

        chk("rst busy", busy, 0);
        chk("rst mac_en", mac_en, 0);
        chk("rst mac_clr", mac_clr, 0);
        chk("rst wb_en", wb_en, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst overrun", overrun, 0);
        chk("rst op_sel", op_sel, 0);
        chk("rst coef_addr", coef_addr, 0);
        chk("rst sec_idx", sec_idx, 0);
        chk("rst1 busy", busy1, 0);

        // Nominal schedule on both builds
        sv = 1'b1; sv1 = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            sv = 1'b0; sv1 = 1'b0;
            chk_nom(c, "nom");
            if (c <= 8) begin
                chk($sformatf("lat0 c%0d mac_en", c), mac_en1, c <= 5);
                chk($sformatf("lat0 c%0d mac_clr", c), mac_clr1, c == 1);
                chk($sformatf("lat0 c%0d coef", c), coef_addr1,
                    (c <= 5) ? c - 1 : 4);
                chk($sformatf("lat0 c%0d wb_en", c), wb_en1, c == 6);
                chk($sformatf("lat0 c%0d out_valid", c), out_valid1, c == 7);
                chk($sformatf("lat0 c%0d busy", c), busy1, c <= 7);
            end
        end

        // Overrun set/clear, then a strobe in the DONE cycle
        sv = 1'b1;
        for (int c = 1; c <= 67; c++) begin
            tick();
            sv = (c == 10) || (c == 12) || (c == 33);
            clr = (c == 12) || (c == 14);
            chk_nom((c <= 33) ? c : c - 33, "ovr");
            chk($sformatf("ovr c%0d overrun", c), overrun,
                c >= 11 && c <= 14);
        end
        clr = 1'b0;

        // Reset during section 2 MAC
        sv = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            sv = (c == 15);
            chk_nom(c, "pre");
        end
        chk("pre overrun", overrun, 1);
        rst = 1'b0;
        tick();
        chk("mid busy", busy, 0);
        chk("mid mac_en", mac_en, 0);
        chk("mid mac_clr", mac_clr, 0);
        chk("mid op_sel", op_sel, 0);
        chk("mid coef_addr", coef_addr, 0);
        chk("mid sec_idx", sec_idx, 0);
        chk("mid overrun", overrun, 0);
        chk("mid wb_en", wb_en, 0);
        chk("mid out_valid", out_valid, 0);
        rst = 1'b1;
        last_addr = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk($sformatf("abort i%0d wb_en", i), wb_en, 0);
            chk($sformatf("abort i%0d out_valid", i), out_valid, 0);
            chk($sformatf("abort i%0d busy", i), busy, 0);
        end
        sv = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            sv = 1'b0;
            chk_nom(c, "post");
        end

        // Sparse strobes over 10000 cycles
        n_ov = 0; max_addr = 0; ovr_seen = 1'b0;
        for (int i = 0; i < 10040; i++) begin
            sv = (i < 10000) && (i % 1000 == 0);
            tick();
            if (out_valid === 1'b1) n_ov++;
            if (int'(coef_addr) > max_addr) max_addr = int'(coef_addr);
            if (overrun !== 1'b0) ovr_seen = 1'b1;
        end
        sv = 1'b0;
        chk("soak out_valid count", n_ov, 10);
        chk("soak max coef_addr", max_addr, 19);
        chk("soak overrun seen", ovr_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iir_mac_scheduler.md
Name: iir_mac_scheduler

Overview:
- Sequencer for a time-multiplexed IIR datapath: one shared multiply-accumulate unit serves a cascade of Direct Form I biquad sections.
- Each accepted input sample triggers a fixed schedule of 5 MAC operations per section, a pipeline drain, then a delay-line writeback.
- Sits between the 48 kHz sample strobe and the IIR MAC/coefficient-memory datapath. Pure control: it carries no sample data.

Parameters:
- SECTIONS, 4, number of cascaded biquad sections (1..16).
- MAC_LAT, 2, pipeline latency of the shared MAC in cycles (0..7); drain cycles inserted before each writeback.
- CADDR_W, 6, width of coef_addr; must satisfy 2^CADDR_W >= 5*SECTIONS.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- sample_valid  in  1  one-cycle strobe: new input sample present on datapath input
- clear_ovr  in  1  clears the sticky overrun flag
- busy  out  1  high from the first MAC cycle through the DONE cycle
- mac_en  out  1  MAC performs an operation this cycle
- mac_clr  out  1  with mac_en: accumulator loads the product instead of adding it
- op_sel  out  3  operand select: 0=x[n], 1=x[n-1], 2=x[n-2], 3=y[n-1], 4=y[n-2]
- coef_addr  out  CADDR_W  coefficient index = 5*sec + tap (b0,b1,b2,-a1,-a2)
- sec_idx  out  4  current section
- wb_en  out  1  shift delay lines of section sec_idx; the accumulator result becomes y[n] and the next section's x[n]
- out_valid  out  1  one-cycle pulse: final-section y[n] is valid
- overrun  out  1  sticky: a sample_valid arrived while busy

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE, all counters 0, every output 0 including overrun. Reset mid-schedule aborts immediately with no wb_en or out_valid.
- States: IDLE, MAC, DRAIN, WB, DONE.
- IDLE: sample_valid -> MAC with sec=0, tap=0.
- MAC: mac_en=1; op_sel=tap; coef_addr=5*sec+tap; mac_clr=1 only when tap==0. After tap 4: go to DRAIN if MAC_LAT>0, else WB.
- DRAIN: MAC_LAT cycles with all strobes low, then WB.
- WB: wb_en=1 for one cycle. If sec==SECTIONS-1, go to DONE; else sec+1, tap=0, go to MAC.
- DONE: out_valid=1 for one cycle. sample_valid in DONE is accepted (next cycle MAC, sec 0); otherwise go to IDLE.
- Timing: strobe at cycle T gives MAC tap0 of sec k at T+1+k*(6+MAC_LAT), WB of sec k at T+(k+1)*(6+MAC_LAT), out_valid at T+1+SECTIONS*(6+MAC_LAT). Defaults: out_valid at T+33.
- busy is high in MAC, DRAIN, WB and DONE.
- Overrun: sample_valid in MAC/DRAIN/WB is dropped, overrun set next cycle, schedule unaffected. If set and clear_ovr coincide, set wins.
- sec_idx, op_sel and coef_addr hold their last values when not strobed. They read 0 after reset.
- At most one of mac_en, wb_en, out_valid is high in any cycle.

Decomposition:
- Shared package iir_pkg: state encoding constants, op_sel encodings (OP_X0..OP_Y2), TAPS_PER_SEC=5.
- Sub-module iir_tap_counter: tap/drain counter with terminal flags, reused by the state machine.
- Address multiply 5*sec is built as (sec<<2)+sec.

Test Plan:
- Reset then single strobe, defaults -> mac_en high at T+1..T+5, mac_clr only at T+1, coef_addr 0..4, wb_en at T+8, coef_addr 5 at T+9, out_valid only at T+33, busy low at T+34.
- MAC_LAT=0, SECTIONS=1 -> MAC at T+1..T+5, wb_en at T+6, out_valid at T+7, no DRAIN cycles.
- Strobe at T+10 during busy -> schedule unchanged, out_valid still at T+33, overrun=1 from T+11. clear_ovr alone -> 0; clear_ovr with a busy strobe -> stays 1.
- Strobe exactly in DONE cycle (T+33) -> next MAC tap0 at T+34 with coef_addr 0, no overrun.
- rst low during sec 2 MAC -> next cycle all outputs 0, state IDLE; no wb_en/out_valid; fresh strobe gives nominal timing.
- Back-to-back strobes every 1000 cycles for 10000 cycles -> exactly 10 out_valid pulses, overrun never set, coef_addr never exceeds 19.
